// File: rtl/seq_arith_accum_pkg.sv
// Package for the multi-channel accumulator: opcode encoding shared by the
// top level, the ALU and anything that drives requests into the block.
package seq_arith_accum_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } accum_op_t;

endpackage

// File: rtl/seq_arith_accum_alu.sv
// Combinational update for one accumulator channel.
//   acc    : current accumulator value
//   data   : request operand (ignored for CLR)
//   op     : ADD / SUB / LOAD / CLR
//   result : next accumulator value (wrapped or clamped according to SAT)
//   ovf    : this update overflowed (ADD/SUB only; never set by LOAD/CLR)
module seq_arith_accum_alu
    import seq_arith_accum_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int SAT    = 0,
    parameter int SIGNED = 0
) (
    input  logic [NBITS-1:0] acc,
    input  logic [NBITS-1:0] data,
    input  accum_op_t        op,
    output logic [NBITS-1:0] result,
    output logic             ovf
);

    localparam logic [NBITS-1:0] SMAX = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] SMIN = {1'b1, {(NBITS-1){1'b0}}};

    // One extra bit captures the unsigned carry (ADD) or borrow (SUB).
    logic [NBITS:0] sum;
    logic [NBITS:0] diff;
    logic           acc_s;
    logic           data_s;

    assign sum    = {1'b0, acc} + {1'b0, data};
    assign diff   = {1'b0, acc} - {1'b0, data};
    assign acc_s  = acc[NBITS-1];
    assign data_s = data[NBITS-1];

    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = sum[NBITS-1:0];
                if (SIGNED != 0) ovf = (acc_s == data_s) && (sum[NBITS-1] != acc_s);
                else             ovf = sum[NBITS];
                if ((SAT != 0) && ovf) begin
                    if (SIGNED != 0) result = acc_s ? SMIN : SMAX;
                    else             result = '1;
                end
            end
            OP_SUB: begin
                result = diff[NBITS-1:0];
                if (SIGNED != 0) ovf = (acc_s != data_s) && (diff[NBITS-1] != acc_s);
                else             ovf = diff[NBITS];
                if ((SAT != 0) && ovf) begin
                    // Signed SUB overflow always moves away from zero in the
                    // direction of acc's sign, so acc's sign picks the rail.
                    if (SIGNED != 0) result = acc_s ? SMIN : SMAX;
                    else             result = '0;
                end
            end
            OP_LOAD: result = data;
            OP_CLR:  result = '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/seq_arith_accum_mc.sv
// Multi-channel running-sum accumulator with a one-entry valid/ready output.
//   clk, reset           : clock, asynchronous active-low reset
//   in_val/in_rdy        : request handshake (in_rdy = !out_val || out_rdy)
//   in_op/in_chan/in_data: opcode, target channel, operand
//   out_val/out_rdy      : result handshake
//   out_chan/out_data/out_ovf : channel, accumulator after update, sticky flag
// A request for a channel >= NCHAN is consumed and reports data 0, ovf 0.
module seq_arith_accum_mc
    import seq_arith_accum_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int NCHAN  = 4,
    parameter int SAT    = 0,
    parameter int SIGNED = 0,
    localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [OP_W-1:0]  in_op,
    input  logic [CW-1:0]    in_chan,
    input  logic [NBITS-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [CW-1:0]    out_chan,
    output logic [NBITS-1:0] out_data,
    output logic             out_ovf
);

    logic [NBITS-1:0] acc_q [NCHAN];
    logic [NBITS-1:0] acc_d [NCHAN];
    logic             ovf_q [NCHAN];
    logic             ovf_d [NCHAN];

    logic             out_val_q, out_val_d;
    logic [CW-1:0]    out_chan_q, out_chan_d;
    logic [NBITS-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    accum_op_t        op;
    logic             accept;
    logic             chan_ok;
    logic [NBITS-1:0] acc_sel;
    logic [NBITS-1:0] alu_result;
    logic             alu_ovf;
    logic             flag_new;

    assign op      = accum_op_t'(in_op);
    assign in_rdy  = !out_val_q || out_rdy;
    assign accept  = in_val && in_rdy;
    assign chan_ok = (int'(in_chan) < NCHAN);
    // Read the register directly so a back-to-back request to the same
    // channel sees the update from the previous edge.
    assign acc_sel = chan_ok ? acc_q[in_chan] : '0;

    seq_arith_accum_alu #(
        .NBITS  (NBITS),
        .SAT    (SAT),
        .SIGNED (SIGNED)
    ) u_alu (
        .acc    (acc_sel),
        .data   (in_data),
        .op     (op),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // LOAD/CLR restart the channel; ADD/SUB accumulate into the sticky flag.
    assign flag_new = ((op == OP_LOAD) || (op == OP_CLR)) ? 1'b0
                    : (chan_ok ? ovf_q[in_chan] : 1'b0) | alu_ovf;

    always_comb begin
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_val_d  = out_val_q && !out_rdy;
        out_chan_d = out_chan_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (accept) begin
            out_val_d  = 1'b1;
            out_chan_d = in_chan;
            out_data_d = '0;
            out_ovf_d  = 1'b0;
            if (chan_ok) begin
                acc_d[in_chan] = alu_result;
                ovf_d[in_chan] = flag_new;
                out_data_d     = alu_result;
                out_ovf_d      = flag_new;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge.
    // NOTE: the accumulator array is reset explicitly; it is a handful of
    // flops whose zero state is observable, not a RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCHAN; i++) begin
                acc_q[i] <= '0;
                ovf_q[i] <= 1'b0;
            end
            out_val_q  <= 1'b0;
            out_chan_q <= '0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_val_q  <= out_val_d;
            out_chan_q <= out_chan_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_val  = out_val_q;
    assign out_chan = out_chan_q;
    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_seq_arith_accum_mc.sv
// Directed bench for seq_arith_accum_mc. Five instances cover the parameter
// corners: 0 = wrap/unsigned, 1 = sat/unsigned, 2 = sat/signed,
// 3 = wrap/signed, 4 = NCHAN=3 (out-of-range channel). Inputs are shared;
// in_val is steered to one instance at a time.
module tb_seq_arith_accum_mc;

    localparam int ND = 5;
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LOAD = 2'd2, CLR = 2'd3;

    typedef struct {
        int         dut;
        logic [1:0] chan;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_val = 1'b0;
    logic [2:0]    sel = '0;
    logic [1:0]    in_op = '0;
    logic [1:0]    in_chan = '0;
    logic [7:0]    in_data = '0;
    logic          out_rdy = 1'b1;

    logic [ND-1:0] in_val_v;
    logic [ND-1:0] in_rdy_v;
    logic [ND-1:0] o_val;
    logic [ND-1:0] o_ovf;
    logic [1:0]    o_chan [ND];
    logic [7:0]    o_data [ND];

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign in_val_v = in_val ? (ND'(1) << sel) : '0;

    always #5 clk = ~clk;

    seq_arith_accum_mc #(.NBITS(8), .NCHAN(4), .SAT(0), .SIGNED(0)) u_wrap_u (
        .clk(clk), .reset(reset), .in_val(in_val_v[0]), .in_rdy(in_rdy_v[0]),
        .in_op(in_op), .in_chan(in_chan), .in_data(in_data),
        .out_val(o_val[0]), .out_rdy(out_rdy), .out_chan(o_chan[0]),
        .out_data(o_data[0]), .out_ovf(o_ovf[0]));

    seq_arith_accum_mc #(.NBITS(8), .NCHAN(4), .SAT(1), .SIGNED(0)) u_sat_u (
        .clk(clk), .reset(reset), .in_val(in_val_v[1]), .in_rdy(in_rdy_v[1]),
        .in_op(in_op), .in_chan(in_chan), .in_data(in_data),
        .out_val(o_val[1]), .out_rdy(out_rdy), .out_chan(o_chan[1]),
        .out_data(o_data[1]), .out_ovf(o_ovf[1]));

    seq_arith_accum_mc #(.NBITS(8), .NCHAN(4), .SAT(1), .SIGNED(1)) u_sat_s (
        .clk(clk), .reset(reset), .in_val(in_val_v[2]), .in_rdy(in_rdy_v[2]),
        .in_op(in_op), .in_chan(in_chan), .in_data(in_data),
        .out_val(o_val[2]), .out_rdy(out_rdy), .out_chan(o_chan[2]),
        .out_data(o_data[2]), .out_ovf(o_ovf[2]));

    seq_arith_accum_mc #(.NBITS(8), .NCHAN(4), .SAT(0), .SIGNED(1)) u_wrap_s (
        .clk(clk), .reset(reset), .in_val(in_val_v[3]), .in_rdy(in_rdy_v[3]),
        .in_op(in_op), .in_chan(in_chan), .in_data(in_data),
        .out_val(o_val[3]), .out_rdy(out_rdy), .out_chan(o_chan[3]),
        .out_data(o_data[3]), .out_ovf(o_ovf[3]));

    seq_arith_accum_mc #(.NBITS(8), .NCHAN(3), .SAT(0), .SIGNED(0)) u_nch3 (
        .clk(clk), .reset(reset), .in_val(in_val_v[4]), .in_rdy(in_rdy_v[4]),
        .in_op(in_op), .in_chan(in_chan), .in_data(in_data),
        .out_val(o_val[4]), .out_rdy(out_rdy), .out_chan(o_chan[4]),
        .out_data(o_data[4]), .out_ovf(o_ovf[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: drive one request, push its expected
    // result, take the next edge, then pop and compare the presented result.
    task automatic send(input int d, input logic [1:0] op, input logic [1:0] ch,
                        input logic [7:0] data, input logic [7:0] e_data,
                        input logic e_ovf, input string tag);
        exp_t e;
        sel     = 3'(d);
        in_op   = op;
        in_chan = ch;
        in_data = data;
        in_val  = 1'b1;
        sb.push_back('{dut: d, chan: ch, data: e_data, ovf: e_ovf});
        chk({tag, ".in_rdy"}, 32'(in_rdy_v[d]), 32'd1);
        @(posedge clk);
        #1;
        in_val = 1'b0;
        chk({tag, ".out_val"}, 32'(o_val[d]), 32'd1);
        if (o_val[d] && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".out_chan"}, 32'(o_chan[e.dut]), 32'(e.chan));
            chk({tag, ".out_data"}, 32'(o_data[e.dut]), 32'(e.data));
            chk({tag, ".out_ovf"},  32'(o_ovf[e.dut]),  32'(e.ovf));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < ND; i++) begin
            chk("rst.out_val",  32'(o_val[i]),  32'd0);
            chk("rst.out_data", 32'(o_data[i]), 32'd0);
        end
        chk("rst.out_chan", 32'(o_chan[0]), 32'd0);
        chk("rst.out_ovf",  32'(o_ovf[0]),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Wrap, unsigned: running sum with carry-out
        send(0, ADD, 2'd1, 8'd3,   8'd3, 1'b0, "wrap.add3");
        send(0, ADD, 2'd1, 8'd5,   8'd8, 1'b0, "wrap.add5");
        send(0, ADD, 2'd1, 8'd250, 8'd2, 1'b1, "wrap.add250");
        send(0, ADD, 2'd0, 8'd0,   8'd0, 1'b0, "wrap.chan0");
        send(0, ADD, 2'd2, 8'd0,   8'd0, 1'b0, "wrap.chan2");
        send(0, ADD, 2'd3, 8'd0,   8'd0, 1'b0, "wrap.chan3");

        // Backpressure: chan3 result held while a chan1 ADD 4 waits
        out_rdy = 1'b0;
        sel     = 3'd0;
        in_op   = ADD;
        in_chan = 2'd1;
        in_data = 8'd4;
        in_val  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.in_rdy",   32'(in_rdy_v[0]), 32'd0);
            chk("bp.out_val",  32'(o_val[0]),    32'd1);
            chk("bp.out_chan", 32'(o_chan[0]),   32'd3);
            chk("bp.out_data", 32'(o_data[0]),   32'd0);
        end
        out_rdy = 1'b1;
        #1;
        send(0, ADD, 2'd1, 8'd4, 8'd6, 1'b1, "bp.release");
        @(posedge clk);
        #1;
        chk("bp.no_dup", 32'(o_val[0]), 32'd0);

        // Interleaved channels (chan1 cleared first)
        send(0, CLR, 2'd1, 8'd99, 8'd0, 1'b0, "il.clr1");
        for (int i = 0; i < 6; i++)
            send(0, ADD, 2'(i % 4), 8'd1, (i < 4) ? 8'd1 : 8'd2, 1'b0, "il.add1");

        // Saturating, unsigned
        send(1, LOAD, 2'd0, 8'd250, 8'd250, 1'b0, "satu.load");
        send(1, ADD,  2'd0, 8'd10,  8'd255, 1'b1, "satu.add10");
        send(1, SUB,  2'd0, 8'd255, 8'd0,   1'b1, "satu.sub255");
        send(1, CLR,  2'd0, 8'd77,  8'd0,   1'b0, "satu.clr");
        send(1, SUB,  2'd0, 8'd1,   8'd0,   1'b1, "satu.borrow");

        // Saturating, signed
        send(2, LOAD, 2'd2, 8'h7E, 8'h7E, 1'b0, "sats.load7e");
        send(2, ADD,  2'd2, 8'h05, 8'h7F, 1'b1, "sats.add5");
        send(2, LOAD, 2'd2, 8'h81, 8'h81, 1'b0, "sats.load81");
        send(2, SUB,  2'd2, 8'h04, 8'h80, 1'b1, "sats.sub4");

        // Wrap, signed
        send(3, LOAD, 2'd2, 8'h7E, 8'h7E, 1'b0, "wraps.load7e");
        send(3, ADD,  2'd2, 8'h05, 8'h83, 1'b1, "wraps.add5");
        send(3, LOAD, 2'd2, 8'h81, 8'h81, 1'b0, "wraps.load81");
        send(3, SUB,  2'd2, 8'h04, 8'h7D, 1'b1, "wraps.sub4");

        // Out-of-range channel on the 3-channel instance
        send(4, LOAD, 2'd2, 8'd5,   8'd5, 1'b0, "oor.load");
        send(4, ADD,  2'd2, 8'd255, 8'd4, 1'b1, "oor.ovf");
        send(4, ADD,  2'd3, 8'd1,   8'd0, 1'b0, "oor.chan3");
        send(4, ADD,  2'd2, 8'd1,   8'd5, 1'b1, "oor.intact");

        // Async reset mid-cycle with a pending result and non-zero state
        send(0, ADD, 2'd1, 8'd9, 8'd11, 1'b0, "ar.pre");
        #3;
        sel     = 3'd0;
        in_op   = ADD;
        in_chan = 2'd1;
        in_data = 8'd1;
        in_val  = 1'b1;
        reset   = 1'b0;
        #1;
        chk("ar.out_val",  32'(o_val[0]),  32'd0);
        chk("ar.out_data", 32'(o_data[0]), 32'd0);
        chk("ar.out_chan", 32'(o_chan[0]), 32'd0);
        chk("ar.out_ovf",  32'(o_ovf[0]),  32'd0);
        @(posedge clk);
        #1;
        chk("ar.no_accept", 32'(o_val[0]), 32'd0);
        in_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(0, ADD, 2'd1, 8'd7, 8'd7, 1'b0, "ar.add7");
        send(0, ADD, 2'd0, 8'd0, 8'd0, 1'b0, "ar.chan0");
        send(2, ADD, 2'd2, 8'd0, 8'd0, 1'b0, "ar.sats");

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_arith_accum_mc.md
# seq_arith_accum_mc

Parametrised multi-channel accumulator with an add/subtract/load/clear opcode, optional saturation and signed arithmetic, per-channel sticky overflow flags and a one-entry valid/ready output stage. It generalises the single-channel 8-bit running-sum accumulator. It sits in the sequential-arithmetic datapath library and serves as a per-stream running-sum engine between a request source and a result consumer.

## Interface
- `NBITS`, 8: accumulator and operand width (≥2)
- `NCHAN`, 4: number of independent accumulators (≥1)
- `SAT`, 0: 0 = wrap-around arithmetic, 1 = saturating arithmetic
- `SIGNED`, 0: 0 = unsigned operands/accumulators, 1 = two's complement
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_val`  in  1  request valid
- `in_rdy`  out  1  request ready
- `in_op`  in  2  opcode: ADD=0, SUB=1, LOAD=2, CLR=3
- `in_chan`  in  max(1,$clog2(NCHAN))  target channel
- `in_data`  in  NBITS  operand (ignored for CLR)
- `out_val`  out  1  result valid
- `out_rdy`  in  1  result ready
- `out_chan`  out  max(1,$clog2(NCHAN))  channel of result
- `out_data`  out  NBITS  accumulator value after the update
- `out_ovf`  out  1  channel's sticky overflow flag after the update

## Operation
- Request accepted when `in_val && in_rdy`. On acceptance, channel `in_chan` updates at the same edge:
  - ADD: acc + data.
  - SUB: acc − data.
  - LOAD: acc = data.
  - CLR: acc = 0.
- Overflow detection:
  - Unsigned: carry-out on ADD, borrow on SUB.
  - Signed: operand signs equal and result sign differs (ADD); operand signs differ and result sign differs from acc (SUB).
- SAT=0: result wraps mod 2^NBITS.
- SAT=1 on overflow, result clamps:
  - Unsigned: ADD → all-ones, SUB → 0.
  - Signed: positive overflow → 2^(NBITS−1)−1, negative overflow → −2^(NBITS−1).
- Sticky flag per channel:
  - Set on any ADD/SUB overflow, in both SAT modes.
  - Cleared by LOAD or CLR on that channel.
  - Holds otherwise.
- `in_chan` ≥ NCHAN: request is accepted and consumed. No accumulator changes. Result reports `out_data`=0, `out_ovf`=0.
- Channels are fully independent. Only the addressed channel's state changes.

## Timing
- Reset (async assert, sync release internally not required):
  - All accumulators = 0.
  - All ovf flags = 0.
  - `out_val`=0, `out_chan`=0, `out_data`=0, `out_ovf`=0.
- Latency: 1 cycle. The result of a request accepted at edge N is presented from edge N onward with `out_val`=1.
- `in_rdy` = !out_val || out_rdy (combinational from `out_rdy`). Full throughput: 1 request/cycle when `out_rdy` held high.
- While `out_val && !out_rdy`:
  - `out_*` hold stable.
  - No request is accepted.
  - Accumulators do not change.
- Back-to-back requests to the same channel see the previous update with no bubble. The accumulator register is read combinationally.
- Simultaneous output drain and new acceptance in one cycle: the output register is overwritten with the new result, and `out_val` stays 1.
- Reset asserted mid-stream: the pending result is dropped and all state is cleared immediately. No request is accepted while reset is low.
- `in_val` may drop without acceptance; there is no commitment requirement on the requester.

## Structure
- Package `seq_arith_accum_pkg`:
  - Opcode enum `accum_op_t` (ADD/SUB/LOAD/CLR).
  - Opcode width constant.
- Sub-module `seq_arith_accum_alu`:
  - Purely combinational, parametrised by NBITS/SAT/SIGNED.
  - Inputs: acc, data, op.
  - Outputs: result, ovf.
- Top holds:
  - Accumulator array and flag array.
  - Channel decode.
  - Output pipeline register.
  - Handshake logic.

## Test plan
- Reset, then NBITS=8/NCHAN=4/SAT=0/SIGNED=0, `out_rdy`=1: ADD 3, ADD 5, ADD 250 to chan 1 on consecutive cycles → out_data 3, 8, 2 (wrap); out_ovf 0, 0, 1; chans 0/2/3 remain 0.
- SAT=1 unsigned: LOAD 250, ADD 10, SUB 255 on chan 0 → 250, 255 (ovf=1), 0 (ovf=1). Then CLR → 0, ovf=0.
- SAT=1 SIGNED=1: LOAD 0x7E, ADD 5 → 0x7F, ovf=1. LOAD 0x81, SUB 4 → 0x80, ovf=1. SAT=0 same sequence → 0x83, 0x7D.
- Backpressure: hold `out_rdy`=0 after one result with `in_val`=1.
  - `in_rdy`=0 and outputs frozen for 5 cycles; accumulator unchanged.
  - Release `out_rdy` → next result follows in 1 cycle with correct sum, with no lost or duplicated update.
- Interleaved channels: ADD 1 to chans 0,1,2,3,0,1 back-to-back → results 1,1,1,1,2,2 with correct `out_chan`.
- Async reset asserted between edges with `out_val`=1 and accumulators non-zero → outputs and all state 0 before the next edge. The first post-reset ADD 7 returns 7.
